// File: rtl/priority_encoder_stream.sv
// -----------------------------------------------------------------------------
// priority_encoder_stream
//
// This is the registered, streaming successor of the combinational 8-to-3
// priority encoder. Request bits on din are OR-ed into a sticky pending
// vector. Pending indices are then issued one per valid/ready handshake, and
// each issued bit is cleared from pending.
//
// Parameters:
//   N  number of request inputs (2..256), default 8
//   W  index width, $clog2(N) (localparam)
//
// Ports:
//   clk      in   1  rising-edge clock
//   rst_n    in   1  asynchronous active-low reset
//   din      in   N  request bits, OR-ed into pending each edge
//   flush    in   1  synchronous clear of pending and of the output stage
//   dout     out  W  issued index (registered)
//   valid    out  1  dout holds an un-consumed index (registered)
//   ready    in   1  consumer accepts dout when valid && ready
//   pending  out  N  sticky requests not yet issued (registered)
//
// Build option:
//   PENC_ROUND_ROBIN_EN  defined   -> rotating priority. After issuing s, the
//                                     next search starts at (s-1) mod N.
//                        undefined -> fixed priority. The highest index wins
//                                     and no pointer register exists.
//
// Output stage:
//   state | meaning
//   EMPTY | valid=0, the stage can load a new index
//   FULL  | valid=1, dout waits for ready
// The stage is encoded directly by the valid flop.
// -----------------------------------------------------------------------------
module priority_encoder_stream #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] din,
    input  logic         flush,
    output logic [W-1:0] dout,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] pending
);

    logic [N-1:0] pending_q;
    logic [W-1:0] dout_q;
    logic         valid_q;

    logic         load;
    logic         found;
    logic [W-1:0] sel;
    logic         issue;
    logic [N-1:0] clr_onehot;
    logic [N-1:0] pending_next;

    assign load  = !valid_q || ready;
    assign found = |pending_q;
    assign issue = load && found;

`ifdef PENC_ROUND_ROBIN_EN
    localparam int WP = W + 1;

    logic [W-1:0]   ptr_q;
    logic [W-1:0]   ptr_next;
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] dbl_shift;
    logic [N-1:0]   rot;
    logic [W-1:0]   rot_sel;
    logic [WP-1:0]  sel_sum;

    // Rotate pending right by ptr+1. After that, rot[N-1] is pending[ptr] and
    // lower rot bits walk downward from ptr with wrap. The highest set bit of
    // rot is therefore the first hit of the rotating search.
    always_comb begin
        dbl       = {pending_q, pending_q};
        dbl_shift = dbl >> ({1'b0, ptr_q} + WP'(1));
        rot       = dbl_shift[N-1:0];
    end

    always_comb begin
        rot_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (rot[i]) begin
                rot_sel = W'(i);
            end
        end
    end

    // Map the rotated position back to a request index: (m + ptr + 1) mod N.
    // The sum is at most 2N-1, so one conditional subtract is enough.
    always_comb begin
        sel_sum = {1'b0, rot_sel} + {1'b0, ptr_q} + WP'(1);
        if (sel_sum >= WP'(N)) begin
            sel_sum = sel_sum - WP'(N);
        end
        sel = sel_sum[W-1:0];
    end

    assign ptr_next = (sel == '0) ? W'(N - 1) : (sel - W'(1));

    // The pointer moves only on a load that actually issues an index.
    // A flush leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= W'(N - 1);
        end else if (!flush && issue) begin
            ptr_q <= ptr_next;
        end
    end
`else
    // Fixed priority: the highest set index wins. Later loop iterations
    // override earlier ones, so the top bit has the final say.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
                sel = W'(i);
            end
        end
    end
`endif

    always_comb begin
        clr_onehot = '0;
        if (issue) begin
            clr_onehot[sel] = 1'b1;
        end
    end

    // The set is applied after the clear. A request re-asserted on the same
    // edge that issues it therefore stays pending.
    assign pending_next = (pending_q & ~clr_onehot) | din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
        end else if (flush) begin
            // din is dropped this cycle. dout keeps its last value.
            pending_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pending_q <= pending_next;
            if (load) begin
                valid_q <= found;
                if (found) begin
                    dout_q <= sel;
                end
            end
        end
    end

    assign dout    = dout_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_priority_encoder_stream.sv
module tb_priority_encoder_stream;

    localparam int N  = 8;
    localparam int N6 = 6;

    logic         clk;
    logic         rst_n;
    logic [7:0]   din;
    logic         flush;
    logic [2:0]   dout;
    logic         valid;
    logic         ready;
    logic [7:0]   pending;

    logic [5:0]   din6;
    logic         flush6;
    logic [2:0]   dout6;
    logic         valid6;
    logic         ready6;
    logic [5:0]   pending6;

    int total;
    int bad;

    priority_encoder_stream #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .flush(flush),
        .dout(dout), .valid(valid), .ready(ready), .pending(pending)
    );

    priority_encoder_stream #(.N(N6)) dut6 (
        .clk(clk), .rst_n(rst_n), .din(din6), .flush(flush6),
        .dout(dout6), .valid(valid6), .ready(ready6), .pending(pending6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model of the 8-input instance, kept as plain integers and bits.
    bit m_req [N];
    int m_dout;
    bit m_valid;
    int m_ptr;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) m_req[k] = 0;
        m_dout  = 0;
        m_valid = 0;
        m_ptr   = N - 1;
    endfunction

    function automatic int model_pick();
`ifdef PENC_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr - k + N) % N;
            if (m_req[idx]) return idx;
        end
`else
        for (int idx = N - 1; idx >= 0; idx--) begin
            if (m_req[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    function automatic void model_edge(input logic [7:0] d, input logic r, input logic f);
        int s;
        if (f) begin
            for (int k = 0; k < N; k++) m_req[k] = 0;
            m_valid = 0;
            return;
        end
        if (!m_valid || r) begin
            s = model_pick();
            if (s >= 0) begin
                m_dout  = s;
                m_valid = 1;
                m_req[s] = 0;
                m_ptr   = (s + N - 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        for (int k = 0; k < N; k++) if (d[k]) m_req[k] = 1;
    endfunction

    function automatic logic [7:0] model_pend();
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k] = m_req[k];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic r, input logic f);
        din   = d;
        ready = r;
        flush = f;
        @(posedge clk);
        model_edge(d, r, f);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       r;
        logic       f;
        logic [2:0] e_dout;
        logic       e_valid;
        logic [7:0] e_pend;
    } vec_t;

    vec_t tbl[$];

    int exp_starve [6];

    initial begin
        total = 0;
        bad   = 0;
        din = '0; ready = 1'b0; flush = 1'b0; rst_n = 1'b0;
        din6 = '0; ready6 = 1'b1; flush6 = 1'b0;
        model_reset();

        // Reset state, then release: outputs stay quiet while din is idle.
        #12;
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_pend", 32'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        chk("idle_valid", 32'(valid), 0);
        chk("idle_pend", 32'(pending), 0);

        // Asynchronous reset asserted mid-cycle while requests are in flight.
        step(8'hA5, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout), 0);
        chk("async_rst_valid", 32'(valid), 0);
        chk("async_rst_pend", 32'(pending), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: ordered drain, backpressure, flush, set-wins.
        tbl.push_back('{8'h09, 1'b1, 1'b0, 3'd0, 1'b0, 8'h09});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h01});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00});
        tbl.push_back('{8'h42, 1'b0, 1'b0, 3'd0, 1'b0, 8'h42});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{8'h00, 1'b0, 1'b0, 3'd6, 1'b1, 8'h02});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00});
        tbl.push_back('{8'hF0, 1'b0, 1'b0, 3'd1, 1'b0, 8'hF0});
        tbl.push_back('{8'h00, 1'b0, 1'b0, 3'd7, 1'b1, 8'h70});
        tbl.push_back('{8'h01, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00});
        tbl.push_back('{8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00});
        tbl.push_back('{8'h40, 1'b1, 1'b0, 3'd7, 1'b0, 8'h40});
        tbl.push_back('{8'h40, 1'b1, 1'b0, 3'd6, 1'b1, 8'h40});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd6, 1'b1, 8'h00});
        tbl.push_back('{8'h00, 1'b1, 1'b0, 3'd6, 1'b0, 8'h00});

        foreach (tbl[i]) begin
            step(tbl[i].d, tbl[i].r, tbl[i].f);
            chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pend", i), 32'(pending), 32'(tbl[i].e_pend));
        end

        // Starvation versus rotation with din held at 8'b01000010.
`ifdef PENC_ROUND_ROBIN_EN
        exp_starve = '{6, 1, 6, 1, 6, 1};
`else
        exp_starve = '{6, 6, 6, 6, 6, 6};
`endif
        do_reset();
        step(8'h42, 1'b1, 1'b0);
        chk("starve_pend0", 32'(pending), 32'h42);
        for (int k = 0; k < 6; k++) begin
            step(8'h42, 1'b1, 1'b0);
            chk($sformatf("starve%0d_dout", k), 32'(dout), 32'(exp_starve[k]));
            chk($sformatf("starve%0d_valid", k), 32'(valid), 1);
        end
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0);

        // Non-power-of-two width: all-ones drains 5..0 and never goes past N-1.
        do_reset();
        din6 = 6'h3F;
        @(posedge clk);
        @(negedge clk);
        din6 = '0;
        chk("n6_pend", 32'(pending6), 32'h3F);
        for (int k = 0; k < N6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("n6_dout%0d", k), 32'(dout6), 32'(N6 - 1 - k));
            chk($sformatf("n6_valid%0d", k), 32'(valid6), 1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("n6_empty", 32'(valid6), 0);

        // All-ones on the 8-input instance drains 7..0 in order.
        do_reset();
        step(8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < N; k++) begin
            step(8'h00, 1'b1, 1'b0);
            chk($sformatf("ones_dout%0d", k), 32'(dout), 32'(N - 1 - k));
        end
        step(8'h00, 1'b1, 1'b0);
        chk("ones_empty", 32'(valid), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [7:0] d;
            logic r, f;
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            r = ($urandom_range(0, 9) < 7);
            f = ($urandom_range(0, 63) == 0);
            step(d, r, f);
            chk("rnd_valid", 32'(valid), 32'(m_valid));
            chk("rnd_dout", 32'(dout), 32'(m_dout));
            chk("rnd_pend", 32'(pending), 32'(model_pend()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
